// File: rtl/riscv_defines.sv
// Shared tag-ALU definitions: mode encodings, mode width and the tag scheduler FSM states.
// Modes outside the four named encodings are decoded as OLD by riscv_alu_tag.
package riscv_defines;

    localparam int ALU_MODE_WIDTH = 3;

    localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OLD   = 3'd0;
    localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_AND   = 3'd1;
    localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OR    = 3'd2;
    localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_CLEAR = 3'd3;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_RESP = 1'b1
    } tag_sched_state_e;

endpackage

// File: rtl/riscv_alu_tag.sv
// Combinational tag ALU: AND/OR/CLEAR write a new tag, OLD (and any unknown mode) keeps the old one.
// Zero latency, no flow control.
module riscv_alu_tag
    import riscv_defines::*;
(
    input  logic [ALU_MODE_WIDTH-1:0] mode,
    input  logic [31:0]               a,
    input  logic [31:0]               b,
    output logic [31:0]               result,
    output logic                      we
);

    always_comb begin
        result = '0;
        we     = 1'b0;
        case (mode)
            ALU_MODE_AND: begin
                result = a & b;
                we     = 1'b1;
            end
            ALU_MODE_OR: begin
                result = a | b;
                we     = 1'b1;
            end
            ALU_MODE_CLEAR: begin
                result = '0;
                we     = 1'b1;
            end
            default: begin
                result = '0;
                we     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_tag_alu_sched.sv
// Round-robin share of one tag ALU between EX (lane 0) and LSU (lane 1); response registered 1 cycle after accept.
// A held response blocks new grants until it handshakes; optional grant counters under TAG_SCHED_PERF_CNT_EN.
module riscv_tag_alu_sched
    import riscv_defines::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     req_valid_i,
    output logic [1:0]                     req_ready_o,
    input  logic [1:0][ALU_MODE_WIDTH-1:0] req_mode_i,
    input  logic [1:0][31:0]               req_a_i,
    input  logic [1:0][31:0]               req_b_i,
    output logic [1:0]                     rsp_valid_o,
    input  logic [1:0]                     rsp_ready_i,
    output logic [31:0]                    rsp_result_o,
    output logic                           rsp_we_o
`ifdef TAG_SCHED_PERF_CNT_EN
    ,
    output logic [1:0][CNT_WIDTH-1:0]      grant_cnt_o
`endif
);

    tag_sched_state_e state;
    logic             gnt_idx;
    logic             last_gnt;
    logic             win;
    logic             grant_en;
    logic             rsp_hs;
    logic [31:0]      alu_result;
    logic             alu_we;

    // Only the granted lane's ready counts; a ready on the idle lane is ignored.
    always_comb begin
        rsp_hs      = (state == SCHED_RESP) && rsp_valid_o[gnt_idx] && rsp_ready_i[gnt_idx];
        win         = (&req_valid_i) ? ~last_gnt : req_valid_i[1];
        grant_en    = ((state == SCHED_IDLE) || rsp_hs) && (|req_valid_i);
        req_ready_o = 2'b00;
        if (grant_en) begin
            req_ready_o = win ? 2'b10 : 2'b01;
        end
    end

    riscv_alu_tag u_alu_tag (
        .mode   (req_mode_i[win]),
        .a      (req_a_i[win]),
        .b      (req_b_i[win]),
        .result (alu_result),
        .we     (alu_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SCHED_IDLE;
            gnt_idx      <= 1'b0;
            last_gnt     <= 1'b1;
            rsp_valid_o  <= 2'b00;
            rsp_result_o <= '0;
            rsp_we_o     <= 1'b0;
        end else if (grant_en) begin
            state        <= SCHED_RESP;
            gnt_idx      <= win;
            last_gnt     <= win;
            rsp_valid_o  <= win ? 2'b10 : 2'b01;
            rsp_result_o <= alu_result;
            rsp_we_o     <= alu_we;
        end else if (rsp_hs) begin
            state       <= SCHED_IDLE;
            rsp_valid_o <= 2'b00;
        end
    end

`ifdef TAG_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_o <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_ready_o[i] && (grant_cnt_o[i] != {CNT_WIDTH{1'b1}})) begin
                    grant_cnt_o[i] <= grant_cnt_o[i] + CNT_WIDTH'(1);
                end
            end
        end
    end
`else
    // Counter width only matters when the grant counters are built in.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: doc/riscv_tag_alu_sched.md
RISCV_TAG_ALU_SCHED -- requirements
Module: riscv_tag_alu_sched

Interface
- REQ-001 Parameter: CNT_WIDTH, default 16, width of each performance counter.
- REQ-002 clk  in  1  core clock; all state updates on its rising edge.
- REQ-003 rst_n  in  1  asynchronous, active-low reset.
- REQ-004 req_valid_i  in  2  per-requester request valid; [0] = EX tag propagation, [1] = LSU tag update.
- REQ-005 req_ready_o  out  2  per-requester request accepted this cycle; one-hot or zero.
- REQ-006 req_mode_i  in  2xALU_MODE_WIDTH  per-requester tag ALU mode (OLD/AND/OR/CLEAR).
- REQ-007 req_a_i, req_b_i  in  2x32 each  per-requester source tags.
- REQ-008 rsp_valid_o  out  2  per-requester response valid; one-hot or zero.
- REQ-009 rsp_ready_i  in  2  per-requester response accepted.
- REQ-010 rsp_result_o  out  32  registered destination tag of the granted request.
- REQ-011 rsp_we_o  out  1  tag register-file write enable for the response; 0 for ALU_MODE_OLD.
- REQ-012 grant_cnt_o  out  2xCNT_WIDTH  per-requester grant counters (present only with TAG_SCHED_PERF_CNT_EN).

Function
- REQ-013 The block SHALL share one tag ALU between two requesters, evaluated combinationally on the granted request's operands.
- REQ-014 FSM states SHALL be IDLE and RESP.
- REQ-015 A grant SHALL be possible in IDLE, or in RESP in the cycle the pending response handshakes (rsp_valid_o & rsp_ready_i on the granted lane).
- REQ-016 Grant arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, it wins.
- REQ-017 In a grant cycle, req_ready_o SHALL be asserted for the winner only, and result, we and grant index SHALL be registered.
- REQ-018 After a grant, the next state SHALL be RESP with rsp_valid_o set for the granted lane.
- REQ-019 Latency: response SHALL be valid exactly 1 cycle after request acceptance; back-to-back grants SHALL achieve 1 response per cycle.
- REQ-020 In RESP without rsp_ready_i, rsp_valid_o, rsp_result_o and rsp_we_o SHALL hold stable and no new request SHALL be accepted.
- REQ-021 In RESP with handshake and no pending request, the next state SHALL be IDLE with rsp_valid_o = 0.
- REQ-022 Results: AND -> a&b, OR -> a|b, CLEAR -> 0, we=1; OLD -> we=0, result 0; any undefined mode SHALL be treated as OLD.
- REQ-023 rsp_ready_i on a lane without rsp_valid_o SHALL be ignored.
- REQ-024 req_valid_i deasserted before acceptance SHALL drop the request without side effects.

Reset
- REQ-025 On rst_n low, asynchronously: state=IDLE, rsp_valid_o=0, rsp_result_o=0, rsp_we_o=0, last-grant=1 (requester 0 wins the first contest), counters=0.
- REQ-026 Reset during RESP SHALL discard the pending response; no response is issued after reset release.

Configuration
- REQ-027 With macro TAG_SCHED_PERF_CNT_EN defined, each grant SHALL increment its lane counter, saturating at all-ones; grant_cnt_o present.
- REQ-028 Without TAG_SCHED_PERF_CNT_EN, counters and grant_cnt_o SHALL be absent; all other behaviour identical.

Structure
- REQ-029 ALU_MODE_* encodings and ALU_MODE_WIDTH SHALL come from riscv_defines; the FSM state enum SHALL be added to riscv_defines.
- REQ-030 The tag ALU SHALL be one instance of riscv_alu_tag; arbitration and FSM live in this module.

Verification
- REQ-031 Single: req0 AND a=0xF0F0_00FF, b=0x0FF0_0F0F -> next cycle rsp_valid_o=01, result 0x00F0_000F, we=1.
- REQ-032 Contention: both valid every cycle, rsp_ready_i=11 -> grants alternate 0,1,0,1; first grant to 0.
- REQ-033 Backpressure: req1 OR, rsp_ready_i=00 for 3 cycles -> response held stable, req_ready_o=00; accepted on 4th cycle.
- REQ-034 Mode OLD on req0 -> rsp_we_o=0, result 0; mode CLEAR with a=b=0xFFFF_FFFF -> result 0, we=1.
- REQ-035 Reset asserted mid-RESP -> rsp_valid_o=0 immediately; after release, req0 wins a 2-way contest.
- REQ-036 With TAG_SCHED_PERF_CNT_EN and CNT_WIDTH=4: 17 grants on lane 0 -> grant_cnt_o[0]=0xF.
